mic1_mem_responder: RTL and testbench
=====================================

Name: mic1_mem_responder

Overview:
- Memory responder for the Mic-1 datapath's main-memory interface.
- Owns a word-organised RAM and serves three request types:
  - 32-bit data reads and writes, word-addressed through MAR semantics.
  - 8-bit instruction fetches, byte-addressed through PC semantics.
  - A host load port used to preload programs and constant pools while the CPU is held off.
- Includes a post-reset clear sequencer.
- Sits between the mic1 core and the top-level testbench/loader.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the RAM; power of two, ≥4.
- AW, $clog2(DEPTH_WORDS), RAM word-index width (derived; do not override).
- INIT_CLEAR, 1, 1 = zero the whole RAM after reset; 0 = skip straight to IDLE.

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous active-low reset.
- mem_addr  in  32  data word address (word index, not byte).
- mem_wdata  in  32  write data.
- mem_read  in  1  data read strobe.
- mem_write  in  1  data write strobe.
- mem_rdata  out  32  registered read data.
- rd_valid  out  1  one-cycle pulse: mem_rdata updated.
- mem_addr_instr  in  32  instruction byte address.
- mem_fetch  in  1  fetch strobe.
- mem_rd_instr  out  8  registered fetched byte.
- fetch_valid  out  1  one-cycle pulse: mem_rd_instr updated.
- load_we  in  1  host write request.
- load_addr  in  32  host word address.
- load_data  in  32  host write data.
- load_ready  out  1  host write is accepted this cycle.
- init_done  out  1  clear sequence finished; RAM serviceable.
- err_oob  out  1  sticky out-of-range access flag.

Behaviour:
- Clock and reset:
  - Reset is resetn, synchronous, active-low; clock is clk.
  - During reset: mem_rdata=0, mem_rd_instr=0, rd_valid=0, fetch_valid=0, load_ready=0, err_oob=0, clear pointer=0.
  - init_done=0 if INIT_CLEAR, else 1.
- State machine (package enum): CLEAR, IDLE.
  - Reset → CLEAR if INIT_CLEAR, else IDLE.
  - CLEAR writes 0 to word ptr each cycle, ptr+1; at ptr==DEPTH_WORDS-1 the write occurs, then → IDLE with init_done=1 from the next cycle.
  - Clear takes exactly DEPTH_WORDS cycles.
  - Reset asserted mid-CLEAR restarts CLEAR at ptr=0.
- In CLEAR:
  - All strobes and host writes are ignored.
  - load_ready=0; valid pulses stay 0; err_oob is not updated.
- Data port (IDLE), RAM port A:
  - mem_read sampled high at edge t → mem_rdata = RAM[mem_addr] registered at t, rd_valid=1 during cycle t..t+1.
  - mem_rdata holds until the next read.
  - mem_write sampled high at edge t → RAM[mem_addr] ← mem_wdata at t.
  - Read and write in the same cycle to the same word: read-first (returns old data), write lands.
- Fetch port (IDLE), RAM port B:
  - Word = mem_addr_instr[AW+1:2]; lane = mem_addr_instr[1:0], big-endian (lane 0 = bits 31:24, lane 3 = bits 7:0).
  - Registered at the sampling edge; fetch_valid pulses one cycle.
  - Fetch concurrent with a data write to the same word returns pre-write data.
  - Fetch and data read are fully independent and may occur in the same cycle.
- Host port:
  - load_ready = (state==IDLE) && !mem_read && !mem_write.
  - A write happens when load_we && load_ready; it uses port A.
  - CPU strobes always win; a blocked host holds its request.
- Out of range:
  - Data or host address ≥ DEPTH_WORDS, or fetch word index ≥ DEPTH_WORDS (check the full upper address bits).
  - Write is dropped; read/fetch returns 0 with a normal valid pulse.
  - err_oob←1, sticky until reset.
- Address wrap: none. Out-of-range addresses never alias to low memory.
- Fetch address 0xFFFFFFFF (PC reset value) is out of range: returns 0 and sets err_oob.

Decomposition:
- Package mic1_mem_pkg holds:
  - The state enum.
  - Byte-lane select function (big-endian).
  - LANE constants.
- One sub-module: mic1_dpram, a two-port synchronous RAM (port A read/write read-first, port B read-only), parameterised by DEPTH_WORDS.
- The responder holds the FSM, arbitration, range checks and output registers.

Test Plan:
- Clear: DEPTH_WORDS=16, INIT_CLEAR=1, release reset → init_done rises exactly 16 cycles later; reading each of words 0..15 returns 0x00000000.
- Data write/read: write 0xDEADBEEF to word 5, then read word 5 → mem_rdata=0xDEADBEEF with rd_valid for one cycle; the same-cycle read+write of 0x12345678 returns 0xDEADBEEF, and a later read returns 0x12345678.
- Fetch lanes: word 2 = 0xA1B2C3D4, fetch byte addresses 8,9,10,11 → 0xA1,0xB2,0xC3,0xD4.
- Arbitration: hold load_we to word 3 with 0x55 while mem_write is active for 2 cycles → load_ready=0 for those cycles; host write lands the cycle after; a read of word 3 returns 0x00000055.
- Out of range: write to word 16 with DEPTH_WORDS=16, then fetch 0xFFFFFFFF → err_oob=1 and stays 1; word 0 unchanged; mem_rd_instr=0x00.
- Reset mid-clear: assert resetn=0 at clear pointer 7 for one cycle → clear restarts; init_done rises 16 cycles after release.

Source files
------------

// File: rtl/mic1_mem_responder_pkg.sv
// ---------------------------------------------------------------------------
// mic1_mem_pkg
// Shared types and helpers for the Mic-1 memory responder.
//   mem_state_e : responder FSM states (CLEAR sweeps the RAM, IDLE serves).
//   LANE0..3    : byte-lane indices inside a 32-bit word.
//   lane_byte() : big-endian byte extraction (lane 0 = bits 31:24).
// ---------------------------------------------------------------------------
package mic1_mem_pkg;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } mem_state_e;

    localparam logic [1:0] LANE0 = 2'd0;
    localparam logic [1:0] LANE1 = 2'd1;
    localparam logic [1:0] LANE2 = 2'd2;
    localparam logic [1:0] LANE3 = 2'd3;

    // The lowest byte address of a word carries its most significant byte.
    function automatic logic [7:0] lane_byte(input logic [31:0] word,
                                             input logic [1:0]  lane);
        logic [7:0] b;
        case (lane)
            LANE0:   b = word[31:24];
            LANE1:   b = word[23:16];
            LANE2:   b = word[15:8];
            LANE3:   b = word[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/mic1_mem_responder_if.sv
// ---------------------------------------------------------------------------
// mic1_mem_if
// Bundle of the three request ports served by mic1_mem_responder.
//   Data port  : mem_addr (word index), mem_wdata, mem_read, mem_write ->
//                mem_rdata, rd_valid
//   Fetch port : mem_addr_instr (byte address), mem_fetch ->
//                mem_rd_instr, fetch_valid
//   Host port  : load_we, load_addr, load_data -> load_ready
//   Status     : init_done, err_oob
//
// Handshake rules:
//   - mem_read / mem_write / mem_fetch are single-cycle strobes that are
//     always accepted while init_done=1; they are ignored before that.
//   - rd_valid / fetch_valid pulse for exactly one cycle after the edge that
//     sampled the strobe; the data outputs then hold until the next request.
//   - The host write is a valid/ready pair: it completes on an edge where
//     load_we && load_ready. A host that sees load_ready=0 keeps load_we,
//     load_addr and load_data stable until it is accepted.
// ---------------------------------------------------------------------------
interface mic1_mem_if;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_rdata;
    logic        rd_valid;
    logic [31:0] mem_addr_instr;
    logic        mem_fetch;
    logic [7:0]  mem_rd_instr;
    logic        fetch_valid;
    logic        load_we;
    logic [31:0] load_addr;
    logic [31:0] load_data;
    logic        load_ready;
    logic        init_done;
    logic        err_oob;

    // Responder side.
    modport slave (
        input  mem_addr, mem_wdata, mem_read, mem_write,
        output mem_rdata, rd_valid,
        input  mem_addr_instr, mem_fetch,
        output mem_rd_instr, fetch_valid,
        input  load_we, load_addr, load_data,
        output load_ready, init_done, err_oob
    );

    // CPU / loader side.
    modport master (
        output mem_addr, mem_wdata, mem_read, mem_write,
        input  mem_rdata, rd_valid,
        output mem_addr_instr, mem_fetch,
        input  mem_rd_instr, fetch_valid,
        output load_we, load_addr, load_data,
        input  load_ready, init_done, err_oob
    );
endinterface

// File: rtl/mic1_dpram.sv
// ---------------------------------------------------------------------------
// mic1_dpram
// Two-port synchronous word RAM.
//   Port A : read/write, read-first (a read returns the word as it was
//            before a write on the same edge). rdata_a updates only when
//            re_a is high.
//   Port B : read-only; rdata_b updates only when re_b is high and also
//            sees pre-write data when port A writes the same word.
// Ports: clk, resetn (clears the read registers only), re_a, we_a, addr_a,
//        wdata_a, rdata_a, re_b, addr_b, rdata_b.
// ---------------------------------------------------------------------------
module mic1_dpram #(
    parameter  int DEPTH_WORDS = 1024,
    localparam int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          re_a,
    input  logic          we_a,
    input  logic [AW-1:0] addr_a,
    input  logic [31:0]   wdata_a,
    output logic [31:0]   rdata_a,
    input  logic          re_b,
    input  logic [AW-1:0] addr_b,
    output logic [31:0]   rdata_b
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we_a) begin
            mem[addr_a] <= wdata_a;
        end
    end

    // Reads sample the array before this edge's write is applied.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rdata_a <= '0;
            rdata_b <= '0;
        end else begin
            if (re_a) begin
                rdata_a <= mem[addr_a];
            end
            if (re_b) begin
                rdata_b <= mem[addr_b];
            end
        end
    end

endmodule

// File: rtl/mic1_mem_responder.sv
// ---------------------------------------------------------------------------
// mic1_mem_responder
// Main-memory responder for the Mic-1 datapath. After reset it optionally
// sweeps the RAM to zero (CLEAR), then serves data reads/writes (port A),
// byte instruction fetches (port B) and host preload writes (port A, only
// when the CPU data port is quiet).
// Ports:
//   clk, resetn : clock, synchronous active-low reset
//   bus         : mic1_mem_if.slave (data, fetch, host, status signals)
//   dbg_state   : current FSM state
// Out-of-range addresses never alias: writes are dropped, reads/fetches
// return zero with a normal valid pulse, and err_oob latches until reset.
// ---------------------------------------------------------------------------
module mic1_mem_responder
    import mic1_mem_pkg::*;
#(
    parameter  int DEPTH_WORDS = 1024,
    parameter  bit INIT_CLEAR  = 1'b1,
    localparam int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic       clk,
    input  logic       resetn,
    mic1_mem_if.slave  bus,
    output mem_state_e dbg_state
);

    localparam logic [31:0]   DEPTH_W  = 32'(DEPTH_WORDS);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH_WORDS - 1);

    mem_state_e    state;
    logic [AW-1:0] clr_ptr;
    logic          init_done_q;
    logic          rd_valid_q;
    logic          fetch_valid_q;
    logic          err_oob_q;
    logic          rd_oob_q;
    logic          fetch_oob_q;
    logic [1:0]    lane_q;

    logic          idle;
    logic          cpu_data;
    logic          data_oob;
    logic          fetch_oob;
    logic          load_oob;
    logic          load_ready;
    logic          host_wr;

    logic          a_re;
    logic          a_we;
    logic [AW-1:0] a_addr;
    logic [31:0]   a_wdata;
    logic          b_re;
    logic [31:0]   ram_a;
    logic [31:0]   ram_b;

    assign idle     = (state == ST_IDLE);
    assign cpu_data = bus.mem_read | bus.mem_write;

    // Range checks use the full address so high bits never wrap into RAM.
    assign data_oob  = (bus.mem_addr >= DEPTH_W);
    assign fetch_oob = ({2'b00, bus.mem_addr_instr[31:2]} >= DEPTH_W);
    assign load_oob  = (bus.load_addr >= DEPTH_W);

    // CPU data strobes own port A; the host only gets it on quiet cycles.
    assign load_ready = resetn && idle && !cpu_data;
    assign host_wr    = bus.load_we && load_ready;

    always_comb begin
        a_re    = 1'b0;
        a_we    = 1'b0;
        a_addr  = '0;
        a_wdata = '0;
        if (resetn) begin
            if (!idle) begin
                a_we   = 1'b1;
                a_addr = clr_ptr;
            end else if (cpu_data) begin
                a_re    = bus.mem_read;
                a_we    = bus.mem_write && !data_oob;
                a_addr  = bus.mem_addr[AW-1:0];
                a_wdata = bus.mem_wdata;
            end else if (host_wr) begin
                a_we    = !load_oob;
                a_addr  = bus.load_addr[AW-1:0];
                a_wdata = bus.load_data;
            end
        end
    end

    assign b_re = resetn && idle && bus.mem_fetch;

    mic1_dpram #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_ram (
        .clk     (clk),
        .resetn  (resetn),
        .re_a    (a_re),
        .we_a    (a_we),
        .addr_a  (a_addr),
        .wdata_a (a_wdata),
        .rdata_a (ram_a),
        .re_b    (b_re),
        .addr_b  (bus.mem_addr_instr[AW+1:2]),
        .rdata_b (ram_b)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state         <= INIT_CLEAR ? ST_CLEAR : ST_IDLE;
            clr_ptr       <= '0;
            init_done_q   <= !INIT_CLEAR;
            rd_valid_q    <= 1'b0;
            fetch_valid_q <= 1'b0;
            err_oob_q     <= 1'b0;
            rd_oob_q      <= 1'b0;
            fetch_oob_q   <= 1'b0;
            lane_q        <= LANE0;
        end else begin
            rd_valid_q    <= 1'b0;
            fetch_valid_q <= 1'b0;
            case (state)
                ST_CLEAR: begin
                    clr_ptr <= clr_ptr + AW'(1);
                    if (clr_ptr == LAST_IDX) begin
                        state       <= ST_IDLE;
                        init_done_q <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (bus.mem_read) begin
                        rd_valid_q <= 1'b1;
                        rd_oob_q   <= data_oob;
                    end
                    if (bus.mem_fetch) begin
                        fetch_valid_q <= 1'b1;
                        fetch_oob_q   <= fetch_oob;
                        lane_q        <= bus.mem_addr_instr[1:0];
                    end
                    if ((cpu_data && data_oob) ||
                        (bus.mem_fetch && fetch_oob) ||
                        (host_wr && load_oob)) begin
                        err_oob_q <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // The RAM read registers hold the last word; the remembered out-of-range
    // flag forces zero for accesses that never touched the array.
    assign bus.mem_rdata    = rd_oob_q ? 32'h0 : ram_a;
    assign bus.mem_rd_instr = fetch_oob_q ? 8'h00 : lane_byte(ram_b, lane_q);
    assign bus.rd_valid     = rd_valid_q;
    assign bus.fetch_valid  = fetch_valid_q;
    assign bus.load_ready   = load_ready;
    assign bus.init_done    = init_done_q;
    assign bus.err_oob      = err_oob_q;
    assign dbg_state        = state;

endmodule

// File: tb/tb_mic1_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_mic1_mem_responder
// Directed bench for mic1_mem_responder with DEPTH_WORDS=16, INIT_CLEAR=1.
// A behavioural memory model predicts every output each cycle; directed
// tasks additionally pin hand-computed literal results.
// ---------------------------------------------------------------------------
module tb_mic1_mem_responder;
    import mic1_mem_pkg::*;

    localparam int DEPTH = 16;

    // ---------------- clock / reset ----------------
    logic clk    = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    mic1_mem_if bus();
    mem_state_e dbg_state;

    mic1_mem_responder #(
        .DEPTH_WORDS(DEPTH),
        .INIT_CLEAR (1'b1)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_ram [DEPTH];
    int          m_cleared = 0;      // words swept since the last reset
    logic [31:0] m_rdata   = '0;
    logic        m_rd_valid = 1'b0;
    logic [7:0]  m_instr   = '0;
    logic        m_fetch_valid = 1'b0;
    logic        m_err     = 1'b0;
    int          m_shift;

    initial begin
        forever begin
            @(posedge clk);
            if (!resetn) begin
                m_cleared     = 0;
                m_rdata       = '0;
                m_rd_valid    = 1'b0;
                m_instr       = '0;
                m_fetch_valid = 1'b0;
                m_err         = 1'b0;
            end else if (m_cleared < DEPTH) begin
                m_ram[m_cleared] = '0;
                m_cleared++;
                m_rd_valid    = 1'b0;
                m_fetch_valid = 1'b0;
            end else begin
                m_rd_valid    = bus.mem_read;
                m_fetch_valid = bus.mem_fetch;
                // reads and fetches see memory before this cycle's write
                if (bus.mem_read)
                    m_rdata = (bus.mem_addr < DEPTH) ? m_ram[bus.mem_addr[3:0]] : 32'h0;
                if (bus.mem_fetch) begin
                    m_shift = 8 * (3 - int'(bus.mem_addr_instr[1:0]));
                    if ((bus.mem_addr_instr >> 2) < DEPTH)
                        m_instr = 8'((m_ram[bus.mem_addr_instr[5:2]] >> m_shift) & 32'hFF);
                    else begin
                        m_instr = 8'h00;
                        m_err   = 1'b1;
                    end
                end
                if ((bus.mem_read || bus.mem_write) && bus.mem_addr >= DEPTH)
                    m_err = 1'b1;
                if (bus.mem_write && bus.mem_addr < DEPTH)
                    m_ram[bus.mem_addr[3:0]] = bus.mem_wdata;
                if (bus.load_we && !bus.mem_read && !bus.mem_write) begin
                    if (bus.load_addr < DEPTH) m_ram[bus.load_addr[3:0]] = bus.load_data;
                    else m_err = 1'b1;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            check("cmp_rdata",       bus.mem_rdata,    m_rdata);
            check("cmp_rd_valid",    32'(bus.rd_valid),    32'(m_rd_valid));
            check("cmp_instr",       32'(bus.mem_rd_instr), 32'(m_instr));
            check("cmp_fetch_valid", 32'(bus.fetch_valid), 32'(m_fetch_valid));
            check("cmp_err_oob",     32'(bus.err_oob),     32'(m_err));
            check("cmp_init_done",   32'(bus.init_done),   32'(m_cleared == DEPTH));
            check("cmp_load_ready",  32'(bus.load_ready),
                  32'(resetn && m_cleared == DEPTH && !bus.mem_read && !bus.mem_write));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.mem_addr       = '0;
        bus.mem_wdata      = '0;
        bus.mem_read       = 1'b0;
        bus.mem_write      = 1'b0;
        bus.mem_addr_instr = '0;
        bus.mem_fetch      = 1'b0;
        bus.load_we        = 1'b0;
        bus.load_addr      = '0;
        bus.load_data      = '0;
    endtask

    // Counts edges from now until init_done is seen high (bounded).
    task automatic wait_init(output int n);
        n = 0;
        while (!bus.init_done && n < 100) begin
            step();
            n++;
        end
    endtask

    task automatic write_word(input logic [31:0] addr, input logic [31:0] data);
        bus.mem_addr  = addr;
        bus.mem_wdata = data;
        bus.mem_write = 1'b1;
        step();
        bus.mem_write = 1'b0;
    endtask

    task automatic read_expect(input string name, input logic [31:0] addr,
                               input logic [31:0] exp);
        bus.mem_addr = addr;
        bus.mem_read = 1'b1;
        step();
        bus.mem_read = 1'b0;
        check(name, bus.mem_rdata, exp);
        check({name, "_valid"}, 32'(bus.rd_valid), 32'd1);
    endtask

    task automatic fetch_expect(input string name, input logic [31:0] baddr,
                                input logic [7:0] exp);
        bus.mem_addr_instr = baddr;
        bus.mem_fetch      = 1'b1;
        step();
        bus.mem_fetch = 1'b0;
        check(name, 32'(bus.mem_rd_instr), 32'(exp));
        check({name, "_valid"}, 32'(bus.fetch_valid), 32'd1);
    endtask

    // ---------------- directed sequence ----------------
    int n;

    initial begin
        idle_inputs();
        resetn = 1'b0;
        repeat (3) step();
        check("rst_init_done", 32'(bus.init_done), 32'd0);
        check("rst_rdata",     bus.mem_rdata,      32'h0);
        check("rst_err",       32'(bus.err_oob),   32'd0);
        check("rst_state",     32'(dbg_state),     32'(ST_CLEAR));

        // clear takes exactly DEPTH edges after release
        resetn = 1'b1;
        wait_init(n);
        check("clear_cycles", n, 32'd16);
        for (int i = 0; i < DEPTH; i++) read_expect("clear_word", i, 32'h0);

        // data write / read, read-first on same-cycle read+write
        write_word(5, 32'hDEADBEEF);
        read_expect("rd5", 5, 32'hDEADBEEF);
        step();
        check("rd_valid_pulse", 32'(bus.rd_valid), 32'd0);
        check("rdata_hold", bus.mem_rdata, 32'hDEADBEEF);
        bus.mem_addr  = 5;
        bus.mem_wdata = 32'h12345678;
        bus.mem_read  = 1'b1;
        bus.mem_write = 1'b1;
        step();
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        check("rw_same_old", bus.mem_rdata, 32'hDEADBEEF);
        read_expect("rd5_new", 5, 32'h12345678);

        // fetch lanes, big-endian
        write_word(2, 32'hA1B2C3D4);
        fetch_expect("fetch8",  8,  8'hA1);
        fetch_expect("fetch9",  9,  8'hB2);
        fetch_expect("fetch10", 10, 8'hC3);
        fetch_expect("fetch11", 11, 8'hD4);
        // fetch concurrent with a data write to the same word: pre-write byte
        bus.mem_addr       = 2;
        bus.mem_wdata      = 32'h0F0E0D0C;
        bus.mem_write      = 1'b1;
        bus.mem_addr_instr = 9;
        bus.mem_fetch      = 1'b1;
        step();
        bus.mem_write = 1'b0;
        bus.mem_fetch = 1'b0;
        check("fetch_prewrite", 32'(bus.mem_rd_instr), 32'hB2);
        fetch_expect("fetch_postwrite", 9, 8'h0E);
        // fetch and data read together
        bus.mem_addr       = 5;
        bus.mem_read       = 1'b1;
        bus.mem_addr_instr = 11;
        bus.mem_fetch      = 1'b1;
        step();
        bus.mem_read  = 1'b0;
        bus.mem_fetch = 1'b0;
        check("dual_rdata", bus.mem_rdata, 32'h12345678);
        check("dual_instr", 32'(bus.mem_rd_instr), 32'h0C);

        // arbitration: host blocked while CPU writes for two cycles
        bus.load_we   = 1'b1;
        bus.load_addr = 3;
        bus.load_data = 32'h55;
        bus.mem_addr  = 7;
        bus.mem_wdata = 32'h77;
        bus.mem_write = 1'b1;
        #1;
        check("arb_ready_c1", 32'(bus.load_ready), 32'd0);
        step();
        check("arb_ready_c2", 32'(bus.load_ready), 32'd0);
        step();
        bus.mem_write = 1'b0;
        #1;
        check("arb_ready_free", 32'(bus.load_ready), 32'd1);
        step();
        bus.load_we = 1'b0;
        read_expect("arb_host_word", 3, 32'h00000055);
        read_expect("arb_cpu_word",  7, 32'h00000077);

        // out of range
        write_word(0, 32'h11111111);
        check("oob_err_before", 32'(bus.err_oob), 32'd0);
        write_word(16, 32'h99999999);
        check("oob_err_set", 32'(bus.err_oob), 32'd1);
        read_expect("oob_word0", 0, 32'h11111111);
        fetch_expect("oob_fetch_pc", 32'hFFFFFFFF, 8'h00);
        read_expect("oob_read16", 16, 32'h0);
        repeat (3) step();
        check("oob_err_sticky", 32'(bus.err_oob), 32'd1);

        // reset mid-clear: drop reset once the sweep pointer reaches 7
        resetn = 1'b0;
        repeat (2) step();
        resetn = 1'b1;
        repeat (7) step();
        check("midclr_not_done", 32'(bus.init_done), 32'd0);
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        wait_init(n);
        check("midclr_cycles", n, 32'd16);
        check("midclr_err", 32'(bus.err_oob), 32'd0);
        for (int i = 0; i < DEPTH; i++) read_expect("reclear_word", i, 32'h0);

        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
